// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_add_ctrl_fa_cell.sv
// Combinational 1-bit full adder; the controller reuses a single instance for every bit position.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell walks WIDTH bits LSB first.
// Optional subtract support is enabled by defining SERIAL_ADD_SUB_EN.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             op_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int             CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             fa_sum, fa_cout;
  logic [WIDTH-1:0] a_shr, b_shr, sum_shin;
  logic [WIDTH-1:0] b_load;
  logic             carry_load;

  fa_cell u_fa (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // A 1-bit datapath has nothing to shift; keep the slices legal for that case.
  generate
    if (WIDTH == 1) begin : g_w1
      assign a_shr    = '0;
      assign b_shr    = '0;
      assign sum_shin = fa_sum;
    end else begin : g_wn
      assign a_shr    = {1'b0, a_sr_q[WIDTH-1:1]};
      assign b_shr    = {1'b0, b_sr_q[WIDTH-1:1]};
      assign sum_shin = {fa_sum, sum_q[WIDTH-1:1]};
    end
  endgenerate

`ifdef SERIAL_ADD_SUB_EN
  // Two's-complement subtract: invert B and force carry-in high; cout=1 means no borrow.
  assign b_load     = op_sub ? ~b : b;
  assign carry_load = op_sub ? 1'b1 : cin;
`else
  assign b_load     = b;
  assign carry_load = cin;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = RUN;
          a_sr_d  = a;
          b_sr_d  = b_load;
          carry_d = carry_load;
          cnt_d   = '0;
        end
      end
      RUN: begin
        a_sr_d  = a_shr;
        b_sr_d  = b_shr;
        sum_d   = sum_shin;
        carry_d = fa_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        // On the MSB, carry_q is the carry into the MSB, so overflow falls out directly.
        if (cnt_q == CNT_LAST) begin
          cout_d  = fa_cout;
          ovf_d   = carry_q ^ fa_cout;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl: WIDTH=8 instance plus a WIDTH=1 instance.
module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, cin, out_valid, out_ready, cout, ovf;
  logic [7:0] a, b, sum;
`ifdef SERIAL_ADD_SUB_EN
  logic       op_sub, v1_op_sub;
`endif
  logic       v1_in_valid, v1_in_ready, v1_a, v1_b, v1_cin;
  logic       v1_out_valid, v1_out_ready, v1_sum, v1_cout, v1_ovf;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef SERIAL_ADD_SUB_EN
    .op_sub    (op_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  serial_add_ctrl #(.WIDTH(1)) dut_w1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (v1_in_valid),
    .in_ready  (v1_in_ready),
    .a         (v1_a),
    .b         (v1_b),
    .cin       (v1_cin),
`ifdef SERIAL_ADD_SUB_EN
    .op_sub    (v1_op_sub),
`endif
    .out_valid (v1_out_valid),
    .out_ready (v1_out_ready),
    .sum       (v1_sum),
    .cout      (v1_cout),
    .ovf       (v1_ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Run one WIDTH=8 operation; optionally leave the result parked in DONE.
  task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                        input logic tcin, input logic tsub, input logic [7:0] esum,
                        input logic ecout, input logic eovf, input logic release_res);
    int cyc;
    @(negedge clk);
    a = ta; b = tb_v; cin = tcin; in_valid = 1'b1;
`ifdef SERIAL_ADD_SUB_EN
    op_sub = tsub;
`else
    if (tsub) $display("note: %s subtract request ignored in add-only build", tag);
`endif
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, 32'(cyc), 32'd8);
    check({tag, "_sum"}, 32'(sum), 32'(esum));
    check({tag, "_cout"}, 32'(cout), 32'(ecout));
    check({tag, "_ovf"}, 32'(ovf), 32'(eovf));
    $display("op %s: a=%h b=%h cin=%0d -> sum=%h cout=%0d ovf=%0d after %0d cycles",
             tag, ta, tb_v, tcin, sum, cout, ovf, cyc);
    if (release_res) begin
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "_released"}, 32'({out_valid, in_ready}), 32'b01);
      check({tag, "_sum_kept"}, 32'(sum), 32'(esum));
    end
  endtask

  task automatic run_w1(input logic ta, input logic tb_v, input logic tc);
    logic [1:0] exp;
    string tag;
    exp = 2'(ta) + 2'(tb_v) + 2'(tc);
    tag = $sformatf("w1_%0d%0d%0d", ta, tb_v, tc);
    @(negedge clk);
    v1_a = ta; v1_b = tb_v; v1_cin = tc; v1_in_valid = 1'b1;
    @(negedge clk);
    v1_in_valid = 1'b0;
    check({tag, "_early"}, 32'(v1_out_valid), 32'd0);
    @(negedge clk);
    check({tag, "_valid"}, 32'(v1_out_valid), 32'd1);
    check({tag, "_res"}, 32'({v1_cout, v1_sum}), 32'(exp));
    check({tag, "_ovf"}, 32'(v1_ovf), 32'(tc ^ exp[1]));
    $display("op %s: {cout,sum}=%0d ovf=%0d", tag, {v1_cout, v1_sum}, v1_ovf);
    v1_out_ready = 1'b1;
    @(negedge clk);
    v1_out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    v1_in_valid = 1'b0; v1_out_ready = 1'b0; v1_a = 1'b0; v1_b = 1'b0; v1_cin = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    op_sub = 1'b0; v1_op_sub = 1'b0;
`endif

    // 1. reset state, held for three cycles
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("rst%0d_ready_valid", i), 32'({in_ready, out_valid}), 32'b10);
      check($sformatf("rst%0d_result", i), 32'({sum, cout, ovf}), 32'd0);
    end
    rst_n = 1'b1;

    // 2./3. plain adds
    run_op("add_35_0a", 8'h35, 8'h0A, 1'b0, 1'b0, 8'h3F, 1'b0, 1'b0, 1'b1);
    run_op("add_ff_01_c", 8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 1'b1);
    run_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b1);

    // 4. back-pressure in DONE with a competing request
    run_op("bp_35_0a", 8'h35, 8'h0A, 1'b0, 1'b0, 8'h3F, 1'b0, 1'b0, 1'b0);
    a = 8'hFF; b = 8'hFF; cin = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("bp%0d_ready_valid", i), 32'({in_ready, out_valid}), 32'b01);
      check($sformatf("bp%0d_sum", i), 32'(sum), 32'h3F);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_after_ready_valid", 32'({in_ready, out_valid}), 32'b10);
    check("bp_after_sum", 32'(sum), 32'h3F);
    $display("op backpressure: held 5 cycles, sum=%h", sum);

    // 5. reset in the middle of RUN, after bit 3
    @(negedge clk);
    a = 8'hFF; b = 8'h01; cin = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_ready_valid", 32'({in_ready, out_valid}), 32'b10);
    check("midrst_result", 32'({sum, cout, ovf}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    $display("op midrun_reset: sum=%h cout=%0d ovf=%0d", sum, cout, ovf);
    run_op("add_12_34", 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0, 1'b1);

    // 6. WIDTH=1 exhaustive, then subtract vectors when built in
    for (int k = 0; k < 8; k++) begin
      run_w1(k[2], k[1], k[0]);
    end
`ifdef SERIAL_ADD_SUB_EN
    run_op("sub_10_01", 8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1, 1'b0, 1'b1);
    run_op("sub_01_02", 8'h01, 8'h02, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
